// File: rtl/async_fifo_lvl.sv
// async_fifo_lvl: dual-clock FIFO with Gray-coded pointer crossing, per-domain fill levels,
// programmable almost-full / almost-empty watermarks and sticky overflow / underflow flags.
//
// Optional feature: define FIFO_FWFT_EN for a first-word-fall-through read port. Otherwise
// the read port is registered: data arrives one i_rclk cycle after a read is accepted.
//
// Ports
//   i_wclk, i_rclk      write / read clocks (mutually asynchronous)
//   i_rst_n             asynchronous active-low reset, clears both domains
//   i_wr, i_wdata       write request and data (i_wclk)
//   i_wovf_clr          clears o_woverflow (i_wclk)
//   o_wfull, o_wafull   full / almost-full (i_wclk)
//   o_wlevel            write-side fill level, may overstate occupancy (i_wclk)
//   o_woverflow         sticky: write attempted while full (i_wclk)
//   i_rd                read request; FWFT: pop acknowledge (i_rclk)
//   i_rund_clr          clears o_runderflow (i_rclk)
//   o_rdata, o_rvalid   read data and its valid flag (i_rclk)
//   o_rempty, o_raempty empty / almost-empty (i_rclk)
//   o_rlevel            read-side fill level, may understate occupancy (i_rclk)
//   o_runderflow        sticky: read attempted while empty (i_rclk)

`timescale 1ns / 1ps

module async_fifo_lvl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                       i_wclk,
    input  logic                       i_rst_n,
    input  logic                       i_rclk,
    input  logic                       i_wr,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_wovf_clr,
    output logic                       o_wfull,
    output logic                       o_wafull,
    output logic [$clog2(DEPTH):0]     o_wlevel,
    output logic                       o_woverflow,
    input  logic                       i_rd,
    input  logic                       i_rund_clr,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_rvalid,
    output logic                       o_rempty,
    output logic                       o_raempty,
    output logic [$clog2(DEPTH):0]     o_rlevel,
    output logic                       o_runderflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] AFULL_LVL  = (AW + 1)'(AFULL_THRESH);
    localparam logic [AW:0] AEMPTY_LVL = (AW + 1)'(AEMPTY_THRESH);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = int'(AW) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------------------------------
    logic [AW:0] wbin, wbin_next, wgray, wlevel, rgray_s;
    logic [AW:0] rgray_sync [SYNC_STAGES];
    logic        wfull, wr_en, woverflow;

    assign rgray_s = rgray_sync[SYNC_STAGES-1];

    always_comb begin
        // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
        wfull     = (wgray == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
        wr_en     = i_wr && !wfull;
        wbin_next = wbin + {{AW{1'b0}}, wr_en};
        wlevel    = wbin - gray2bin(rgray_s);
    end

    always_ff @(posedge i_wclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wbin      <= '0;
            wgray     <= '0;
            woverflow <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= bin2gray(wbin_next);
            if (i_wr && wfull) begin
                woverflow <= 1'b1;
            end else if (i_wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_wclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                rgray_sync[i] <= '0;
            end
        end else begin
            rgray_sync[0] <= rgray;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                rgray_sync[i] <= rgray_sync[i-1];
            end
        end
    end

    always_ff @(posedge i_wclk) begin
        if (wr_en) begin
            mem[wbin[AW-1:0]] <= i_wdata;
        end
    end

    assign o_wfull     = wfull;
    assign o_wafull    = (wlevel >= AFULL_LVL);
    assign o_wlevel    = wlevel;
    assign o_woverflow = woverflow;

    // ------------------------------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------------------------------
    logic [AW:0]      rbin, rbin_next, rgray, rlevel, wgray_s;
    logic [AW:0]      wgray_sync [SYNC_STAGES];
    logic             rempty, rd_en, rvalid, runderflow;
    logic [WIDTH-1:0] rdata;

    assign wgray_s = wgray_sync[SYNC_STAGES-1];

    always_ff @(posedge i_rclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                wgray_sync[i] <= '0;
            end
        end else begin
            wgray_sync[0] <= wgray;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                wgray_sync[i] <= wgray_sync[i-1];
            end
        end
    end

`ifdef FIFO_FWFT_EN
    logic mem_empty;

    always_comb begin
        mem_empty = (rgray == wgray_s);
        // Refill the output register whenever it is free or being popped this cycle.
        rd_en     = !mem_empty && (!rvalid || i_rd);
        rbin_next = rbin + {{AW{1'b0}}, rd_en};
        rempty    = !rvalid;
        // The word parked in the output register has already left memory; count it back in.
        rlevel    = gray2bin(wgray_s) - rbin + {{AW{1'b0}}, rvalid};
    end

    always_ff @(posedge i_rclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rbin       <= '0;
            rgray      <= '0;
            rdata      <= '0;
            rvalid     <= 1'b0;
            runderflow <= 1'b0;
        end else begin
            rbin  <= rbin_next;
            rgray <= bin2gray(rbin_next);
            if (rd_en) begin
                rdata  <= mem[rbin[AW-1:0]];
                rvalid <= 1'b1;
            end else if (i_rd) begin
                rvalid <= 1'b0;
            end
            if (i_rd && !rvalid) begin
                runderflow <= 1'b1;
            end else if (i_rund_clr) begin
                runderflow <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        rempty    = (rgray == wgray_s);
        rd_en     = i_rd && !rempty;
        rbin_next = rbin + {{AW{1'b0}}, rd_en};
        rlevel    = gray2bin(wgray_s) - rbin;
    end

    always_ff @(posedge i_rclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rbin       <= '0;
            rgray      <= '0;
            rdata      <= '0;
            rvalid     <= 1'b0;
            runderflow <= 1'b0;
        end else begin
            rbin   <= rbin_next;
            rgray  <= bin2gray(rbin_next);
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= mem[rbin[AW-1:0]];
            end
            if (i_rd && rempty) begin
                runderflow <= 1'b1;
            end else if (i_rund_clr) begin
                runderflow <= 1'b0;
            end
        end
    end
`endif

    assign o_rdata      = rdata;
    assign o_rvalid     = rvalid;
    assign o_rempty     = rempty;
    assign o_raempty    = (rlevel <= AEMPTY_LVL);
    assign o_rlevel     = rlevel;
    assign o_runderflow = runderflow;

endmodule
